// File: rtl/ir_pkg.sv
// ir_pkg: shared SPARC op-field constants and default sizes for the prefetch queue
package ir_pkg;
  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM = 2'b11;
  localparam logic [31:0] NOP_WORD = 32'h0100_0000;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: DEPTH-entry instruction prefetch FIFO; IR_BYPASS_EN adds an empty-queue in-to-out path
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic nonempty, byp, push, pop;
  assign nonempty = count != '0;
`ifdef IR_BYPASS_EN
  assign byp = !nonempty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif
  assign in_ready = count != CNT_W'(DEPTH);
  assign out_valid = nonempty || byp;
  assign out_data = nonempty ? mem[rd_ptr] : byp ? in_data : '0;
  assign out_op = out_data[WIDTH-1 -: 2];
  // a bypassed word taken by the datapath in the same cycle is never stored
  assign push = in_valid && in_ready && !(byp && out_ready);
  assign pop = nonempty && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb_ir_prefetch_queue: directed self-checking bench; bypass checks follow IR_BYPASS_EN
module tb_ir_prefetch_queue;
  logic clk = 0, rst_n = 1, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] in_data = '0, out_data;
  logic [1:0] out_op;
  logic [2:0] count;
  int checks = 0, errors = 0;
  ir_prefetch_queue dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3 rst_n = 0;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_op", 32'(out_op), 0);
    step();
    rst_n = 1;
    step();
    in_data = 32'hAAAA_0001;
    in_valid = 1;
    step();
    in_valid = 0;
    check("t2_valid", 32'(out_valid), 1);
    check("t2_data", out_data, 32'hAAAA_0001);
    check("t2_op", 32'(out_op), 2);
    check("t2_count", 32'(count), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold", out_data, 32'hAAAA_0001);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    check("t2_drain", 32'(count), 0);
    check("t2_empty_data", out_data, 0);
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      in_valid = 1;
      step();
    end
    check("t3_full_count", 32'(count), 4);
    check("t3_full_ready", 32'(in_ready), 0);
    in_data = 5;
    step();
    check("t3_refuse", 32'(count), 4);
    check("t3_head", out_data, 1);
    out_ready = 1;
    step();
    check("t3_full_pop", 32'(count), 3);
    in_valid = 0;
    for (int i = 2; i <= 4; i++) begin
      check("t3_order", out_data, i);
      step();
    end
    out_ready = 0;
    check("t3_empty", 32'(count), 0);
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'h10 + i;
      step();
    end
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      in_data = 32'h12 + k;
      check("t4_order", out_data, 32'h10 + k);
      step();
      check("t4_count", 32'(count), 2);
    end
    in_valid = 0;
    check("t4_tail0", out_data, 32'h18);
    step();
    check("t4_tail1", out_data, 32'h19);
    step();
    out_ready = 0;
    check("t4_empty", 32'(count), 0);
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h21 + i;
      step();
    end
    check("t5_pre", 32'(count), 3);
    in_data = 32'h24;
    out_ready = 1;
    flush = 1;
    step();
    flush = 0;
    out_ready = 0;
    check("t5_count", 32'(count), 0);
    check("t5_valid", 32'(out_valid), 0);
    check("t5_data", out_data, 0);
    in_data = 32'h0100_0000;
    step();
    in_valid = 0;
    check("t5_nop", out_data, 32'h0100_0000);
    check("t5_nop_count", 32'(count), 1);
    check("t5_nop_op", 32'(out_op), 0);
    out_ready = 1;
    step();
    out_ready = 0;
    check("t5_drain", 32'(count), 0);
    in_data = 32'h4000_0010;
    in_valid = 1;
    out_ready = 1;
    #1;
`ifdef IR_BYPASS_EN
    check("t6_valid", 32'(out_valid), 1);
    check("t6_data", out_data, 32'h4000_0010);
    check("t6_op", 32'(out_op), 1);
    step();
    in_valid = 0;
    out_ready = 0;
    check("t6_count", 32'(count), 0);
`else
    check("t6_nobyp_valid", 32'(out_valid), 0);
    check("t6_nobyp_data", out_data, 0);
    step();
    in_valid = 0;
    out_ready = 0;
    check("t6_count", 32'(count), 1);
    check("t6_data_late", out_data, 32'h4000_0010);
    check("t6_op_late", 32'(out_op), 1);
`endif
    in_data = 32'h77;
    in_valid = 1;
    step();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("rst_mid_count", 32'(count), 0);
    check("rst_mid_valid", 32'(out_valid), 0);
    step();
    rst_n = 1;
    step();
    check("rst_after", 32'(count), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction prefetch queue between instruction RAM and the datapath/control unit.
- Accepts fetched words over a valid/ready handshake.
- Presents the oldest word to the datapath with its own valid/ready handshake.
- Supports a synchronous flush on branch/trap.
- Decodes the SPARC op field of the head entry for the control unit.

Parameters:
WIDTH, 32, instruction word width in bits; WIDTH >= 8.
DEPTH, 4, queue entries; power of 2, >= 2.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count; derived, not overridden.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
in_data  in  WIDTH  fetched word from instruction RAM.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  queue can accept a word this cycle.
flush  in  1  discard all queued words (branch taken/trap).
out_data  out  WIDTH  oldest queued word to the datapath.
out_valid  out  1  out_data holds a valid instruction.
out_ready  in  1  datapath consumes out_data this cycle.
out_op  out  2  out_data[WIDTH-1:WIDTH-2]; SPARC op field of the head entry.
count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous: rst_n low immediately forces count=0, rd_ptr=wr_ptr=0, and all storage entries to 0. Resulting outputs: out_valid=0, out_data=0, out_op=0, in_ready=1.
- Storage is DEPTH x WIDTH registers with rd_ptr/wr_ptr of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH naturally. count tracks occupancy separately, so full and empty are unambiguous.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both take effect on the rising clk edge.
- in_ready = (count != DEPTH). It is combinational from state only and never depends on out_ready. A full queue refuses a push even when a pop happens in the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else 0. out_op is taken from out_data.
- Latency: a word pushed into an empty queue appears on out_data/out_valid in the next cycle (1-cycle latency).
- Simultaneous push and pop (0 < count < DEPTH): both pointers advance and count is unchanged. The word order is preserved.
- Push only: the word is written at wr_ptr, wr_ptr+1, count+1. Pop only: rd_ptr+1, count-1.
- out_data stays stable while out_valid=1 and out_ready=0. This is the hold behaviour of the former IRld=0 case.
- Flush has highest priority. On the edge: count=0, rd_ptr=wr_ptr=0. Any push or pop in the same cycle is discarded. Storage contents are not cleared, but out_data reads 0 because the queue is empty.
- Reset mid-operation: queued words are lost. No handshake completes on an edge where rst_n is low.
- Protocol violations are not checked: in_data changing while in_valid=1 and in_ready=0, or out_ready=1 while out_valid=0 (which is harmless and ignored).

Optional Feature:
IR_BYPASS_EN
- Defined: when count==0, in_valid=1 and flush=0, the word passes combinationally to out_data with out_valid=1 and out_op decoded from it. If out_ready=1 in that cycle, the word is consumed and not stored, and count stays 0. Otherwise it is stored as a normal push.
- Undefined: no in-to-out combinational path; the 1-cycle latency above applies.

Decomposition:
- Shared package ir_pkg:
  - SPARC op-field constants: OP_CALL=2'b01, OP_BRANCH=2'b00, OP_ARITH=2'b10, OP_MEM=2'b11.
  - NOP_WORD=32'h0100_0000.
  - Default WIDTH/DEPTH localparams.
- No sub-module is needed. Storage and pointer logic stay inline. The op-field slice is a one-line assign, not a module.

Test Plan:
1. Reset with rst_n=0 asserted mid-cycle -> out_valid=0, out_data=0, count=0, in_ready=1 immediately, without waiting for a clock edge.
2. Push 0xAAAA_0001 into an empty queue with out_ready=0 -> next cycle out_valid=1, out_data=0xAAAA_0001, out_op=2'b10, count=1. out_data is held over 3 more idle cycles.
3. Push 0x1..0x4 back to back with DEPTH=4 and out_ready=0 -> count=4, in_ready=0. A 5th word 0x5 held on in_valid is not accepted. Then out_ready=1 for 4 cycles -> 0x1,0x2,0x3,0x4 appear in order and count returns to 0.
4. Steady stream with in_valid=1 and out_ready=1 at count=2 over 8 cycles -> count stays 2, all words emerge in order, and pointers wrap past index 3 without loss.
5. Queue holds 3 words; flush=1 in the same cycle as in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the pushed word is absent. The following push 0x0100_0000 appears alone.
6. With IR_BYPASS_EN defined, empty queue, push 0x4000_0010 with out_ready=1 -> the same cycle shows out_valid=1, out_data=0x4000_0010, out_op=2'b01, and count remains 0.
